// File: rtl/native_mem_copy_master_if.sv
// PicoRV32 native memory bus bundle.
// master drives requests, slave answers.
interface native_mem_copy_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/native_mem_copy_master.sv
// Word copy DMA master on the native bus.
// Alternating single-word read/write.
module native_mem_copy_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] words_done,
  native_mem_copy_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD, GAP1, WR, GAP2, FIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] rem_q;
  logic             abort_q;
  logic [TW-1:0]    tcnt;
  logic             xfer;
  logic             tmo;
  logic             err_set;
  logic [1:0]       err_nxt;

  assign xfer = bus.mem_valid && bus.mem_ready;
  assign tmo  = bus.mem_valid && !bus.mem_ready
             && (tcnt == TLIM);

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state and error selection
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_nxt   = 2'd0;
    unique case (state)
      IDLE: if (start) state_nxt = CHECK;
      CHECK: begin
        if (src_q[1:0] != 2'd0 ||
            dst_q[1:0] != 2'd0) begin
          state_nxt = FIN;
          err_set   = 1'b1;
          err_nxt   = 2'd1;
        end else if (rem_q == '0) begin
          state_nxt = FIN;
        end else begin
          state_nxt = RD;
        end
      end
      RD, WR: begin
        if (xfer) begin
          state_nxt = (state == RD) ? GAP1 : GAP2;
        end else if (tmo) begin
          state_nxt = FIN;
          err_set   = 1'b1;
          err_nxt   = 2'd2;
        end
      end
      GAP1: begin
        if (abort_q) begin
          state_nxt = FIN;
          err_set   = 1'b1;
          err_nxt   = 2'd3;
        end else begin
          state_nxt = WR;
        end
      end
      GAP2: begin
        if (rem_q == '0) begin
          state_nxt = FIN;
        end else if (abort_q) begin
          state_nxt = FIN;
          err_set   = 1'b1;
          err_nxt   = 2'd3;
        end else begin
          state_nxt = RD;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus and status outputs decoded from state
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'd0;
    unique case (state)
      CHECK, GAP1, GAP2: busy = 1'b1;
      RD: begin
        busy          = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = src_q;
      end
      WR: begin
        busy          = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = dst_q;
        bus.mem_wdata = data_q;
        bus.mem_wstrb = 4'hf;
      end
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // copy datapath, abort latch, timeout counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      data_q     <= 32'd0;
      rem_q      <= '0;
      err_code   <= 2'd0;
      words_done <= '0;
      abort_q    <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (state == IDLE && start) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        rem_q      <= len_words;
        err_code   <= 2'd0;
        words_done <= '0;
      end
      if (err_set) err_code <= err_nxt;
      if (state == RD && xfer)
        data_q <= bus.mem_rdata;
      if (state == WR && xfer) begin
        words_done <= words_done + LEN_W'(1);
        src_q      <= src_q + 32'd4;
        dst_q      <= dst_q + 32'd4;
        rem_q      <= rem_q - LEN_W'(1);
      end
      if (busy) abort_q <= abort_q | abort;
      else      abort_q <= 1'b0;
      if (bus.mem_valid && !bus.mem_ready)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_native_mem_copy_master.sv
// Randomized bench for native_mem_copy_master.
// Memory responder plus transaction-level model.
module tb_native_mem_copy_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] words_done;

  native_mem_copy_master_if bus ();

  native_mem_copy_master #(
    .TIMEOUT_CYCLES(TMO),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .abort(abort),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len_words(len_words),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .words_done(words_done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [int unsigned];
  ent_t        log_q [$];
  int          vcnt;
  int          maxwait = 0;
  bit          noready = 0;
  bit          pend = 0;
  int          wt = 0;
  logic [31:0] p_a, p_d;
  logic [3:0]  p_s;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int nwr();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  // responder: random wait, then one ready cycle
  always @(negedge clk) begin
    if (bus.mem_ready) begin
      bus.mem_ready = 1'b0;
      check("gap", {63'd0, bus.mem_valid}, 64'd0);
      pend = 0;
    end else if (bus.mem_valid) begin
      vcnt++;
      if (pend) begin
        check("stable_a", {32'd0, bus.mem_addr},
              {32'd0, p_a});
        check("stable_d", {32'd0, bus.mem_wdata},
              {32'd0, p_d});
        check("stable_s", {60'd0, bus.mem_wstrb},
              {60'd0, p_s});
      end else begin
        pend = 1;
        p_a = bus.mem_addr;
        p_d = bus.mem_wdata;
        p_s = bus.mem_wstrb;
        wt = int'($urandom_range(0, maxwait));
        check("instr", {63'd0, bus.mem_instr}, 64'd0);
      end
      if (!noready) begin
        if (wt == 0) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_wstrb == 4'hf) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            log_q.push_back({1'b1, bus.mem_addr,
                             bus.mem_wdata});
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr)
                          ? mem[bus.mem_addr] : 32'd0;
            log_q.push_back({1'b0, bus.mem_addr,
                             bus.mem_rdata});
          end
        end else begin
          wt--;
        end
      end
    end else begin
      pend = 0;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {62'd0, err_code}, 64'd0);
    check({tag, "_wd"}, {48'd0, words_done}, 64'd0);
    check({tag, "_valid"}, {63'd0, bus.mem_valid}, 64'd0);
    check({tag, "_addr"}, {32'd0, bus.mem_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
    check({tag, "_wstrb"}, {60'd0, bus.mem_wstrb}, 64'd0);
  endtask

  // one copy job checked against the transaction model
  task automatic run(input logic [31:0] s,
                     input logic [31:0] d,
                     input int l, input int ab,
                     input bit sa, input int ee);
    logic [31:0] orig [$];
    ent_t        exp [$];
    logic [31:0] w;
    int          lat;
    int          np;
    int          n;
    bit          abd = 0;
    for (int i = 0; i < l; i++) begin
      w = $urandom;
      mem[s + 32'(4 * i)] = w;
      orig.push_back(w);
    end
    log_q.delete();
    vcnt = 0;
    src_addr = s;
    dst_addr = d;
    len_words = 16'(l);
    start = 1'b1;
    abort = sa;
    tick();
    start = 1'b0;
    abort = 1'b0;
    lat = 1;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    while (!done && lat < 3000) begin
      if (ab >= 0 && !abd && bus.mem_valid &&
          bus.mem_wstrb == 4'h0 && nwr() == ab) begin
        abort = 1'b1;
        abd = 1;
      end
      tick();
      abort = 1'b0;
      lat++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("err", {62'd0, err_code}, 64'(ee));
    np = (ee == 0) ? l : (ee == 3) ? ab : 0;
    check("words_done", {48'd0, words_done}, 64'(np));
    for (int i = 0; i < np; i++) begin
      exp.push_back({1'b0, s + 32'(4 * i), orig[i]});
      exp.push_back({1'b1, d + 32'(4 * i), orig[i]});
    end
    if (ee == 3)
      exp.push_back({1'b0, s + 32'(4 * np), orig[np]});
    check("log_len", 64'(log_q.size()), 64'(exp.size()));
    n = (log_q.size() < exp.size())
      ? log_q.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check("log_we", {63'd0, log_q[i].we},
            {63'd0, exp[i].we});
      check("log_addr", {32'd0, log_q[i].a},
            {32'd0, exp[i].a});
      check("log_data", {32'd0, log_q[i].d},
            {32'd0, exp[i].d});
    end
    for (int i = 0; i < np; i++)
      check("dst_mem", {32'd0, mem[d + 32'(4 * i)]},
            {32'd0, orig[i]});
    if (ee == 1) check("no_valid", 64'(vcnt), 64'd0);
    if (ee == 2) check("tmo_valid", 64'(vcnt), 64'(TMO));
    if (ee == 0 && maxwait == 0) begin
      check("latency", 64'(lat), 64'(2 + 4 * l));
      check("valid_cycles", 64'(vcnt), 64'(2 * l));
    end
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int l;
    int ab;
    int k;
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src_addr = 32'd0;
    dst_addr = 32'd0;
    len_words = 16'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (3) tick();
    check_idle("reset");
    resetn = 1'b1;
    tick();

    maxwait = 0;
    run(32'h100, 32'h200, 4, -1, 0, 0);
    run(32'h300, 32'h400, 0, -1, 0, 0);
    check("len0_no_valid", 64'(vcnt), 64'd0);
    run(32'h102, 32'h200, 3, -1, 0, 1);
    run(32'h100, 32'h201, 3, -1, 0, 1);
    noready = 1;
    run(32'h100, 32'h200, 3, -1, 0, 2);
    noready = 0;
    maxwait = 2;
    run(32'h600, 32'h700, 5, 1, 0, 3);
    run(32'hffff_fff8, 32'h3000, 4, -1, 0, 0);

    for (int it = 0; it < 10; it++) begin
      maxwait = int'($urandom_range(0, 3));
      l = int'($urandom_range(1, 6));
      ab = ($urandom_range(0, 2) == 0)
         ? int'($urandom_range(0, l - 1)) : -1;
      run(32'h1000 + {22'd0, 8'($urandom), 2'b00},
          32'h8000 + {22'd0, 8'($urandom), 2'b00},
          l, ab, 1'($urandom), (ab >= 0) ? 3 : 0);
    end

    maxwait = 2;
    src_addr = 32'h400;
    dst_addr = 32'h500;
    len_words = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bus.mem_valid && bus.mem_wstrb == 4'h0)
           && k < 50) begin
      tick();
      k++;
    end
    check("t6_read_seen", {63'd0, bus.mem_valid}, 64'd1);
    src_addr = 32'h900;
    dst_addr = 32'ha00;
    len_words = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bus.mem_valid && bus.mem_wstrb == 4'hf)
           && k < 50) begin
      tick();
      k++;
    end
    check("t6_write_seen", {63'd0, bus.mem_valid}, 64'd1);
    check("t6_write_addr", {32'd0, bus.mem_addr},
          64'h500);
    resetn = 1'b0;
    tick();
    check_idle("midreset");
    resetn = 1'b1;
    tick();
    maxwait = 1;
    run(32'h2000, 32'h2800, 3, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
